// File: rtl/iir_pkg.sv
// Shared definitions for the biquad IIR multiply-accumulate engine.
// Holds datapath widths, the default fixed-point fraction, the coefficient
// selector codes seen by the external coefficient mux, and the FSM encoding.
package iir_pkg;

   localparam int DATA_W   = 25;
   localparam int PROD_W   = 2 * DATA_W;
   localparam int ACC_W    = PROD_W + 3;
   localparam int FRAC_DEF = 14;

   localparam logic [2:0] SEL_A1   = 3'b000;
   localparam logic [2:0] SEL_A2   = 3'b001;
   localparam logic [2:0] SEL_B0   = 3'b010;
   localparam logic [2:0] SEL_B1   = 3'b011;
   localparam logic [2:0] SEL_B2   = 3'b100;
   localparam logic [2:0] SEL_IDLE = 3'b110;

   localparam logic [2:0] LAST_STEP = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MAC  = 2'b01,
      ST_OUT  = 2'b10
   } state_t;

   // MAC step to coefficient code: b-terms first, then the feedback a-terms.
   function automatic logic [2:0] step_sel(input logic [2:0] step);
      logic [2:0] sel;
      case (step)
         3'd0:    sel = SEL_B0;
         3'd1:    sel = SEL_B1;
         3'd2:    sel = SEL_B2;
         3'd3:    sel = SEL_A1;
         3'd4:    sel = SEL_A2;
         default: sel = SEL_IDLE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/iir_sat25.sv
// Scales the accumulator back to sample format and saturates to 25 bits.
// Ports:
//   acc    - 53-bit signed accumulator value
//   result - (acc >>> FRAC) clamped to the signed 25-bit range
module iir_sat25
   import iir_pkg::*;
#(
   parameter int FRAC = FRAC_DEF
) (
   input  logic signed [ACC_W-1:0]  acc,
   output logic signed [DATA_W-1:0] result
);

   localparam logic signed [ACC_W-1:0]  R_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
   localparam logic signed [ACC_W-1:0]  R_MIN = ACC_W'(-(2 ** (DATA_W - 1)));
   localparam logic signed [DATA_W-1:0] Y_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
   localparam logic signed [DATA_W-1:0] Y_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

   logic signed [ACC_W-1:0] shifted;

   // Arithmetic shift rounds toward -inf; then clamp to the output range.
   always_comb begin
      shifted = acc >>> FRAC;
      if (shifted > R_MAX) begin
         result = Y_MAX;
      end else if (shifted < R_MIN) begin
         result = Y_MIN;
      end else begin
         result = shifted[DATA_W-1:0];
      end
   end

endmodule

// File: rtl/iir_biquad_mac.sv
// Serial direct-form-I biquad: one shared multiplier walks the five
// coefficient/operand pairs, then the result is scaled, saturated and fed
// back into the delay line.  y = b0*x + b1*x1 + b2*x2 + a1*y1 + a2*y2.
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   sample_valid  - one-cycle strobe qualifying sample_in
//   sample_in     - x[n]
//   constantes    - coefficient from the external mux for 'selector'
//   selector      - coefficient select towards the external mux
//   sample_out    - y[n], held until the next result
//   out_valid     - one-cycle pulse qualifying sample_out
//   busy          - high whenever the engine is not idle
//   overrun       - one-cycle pulse after a strobe that arrived while busy
module iir_biquad_mac
   import iir_pkg::*;
#(
   parameter int FRAC = FRAC_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sample_valid,
   input  logic signed [DATA_W-1:0] sample_in,
   input  logic signed [DATA_W-1:0] constantes,
   output logic [2:0]               selector,
   output logic signed [DATA_W-1:0] sample_out,
   output logic                     out_valid,
   output logic                     busy,
   output logic                     overrun
);

   state_t                    state_r, state_nx_s;
   logic [2:0]                step_r, step_nx_s;
   logic [2:0]                selector_r, sel_nx_s;
   logic                      busy_r, out_valid_r, overrun_r;
   logic signed [DATA_W-1:0]  x0_r, x1_r, x2_r, y1_r, y2_r, sample_out_r;
   logic signed [ACC_W-1:0]   acc_r;
   logic signed [DATA_W-1:0]  operand_s;
   logic signed [PROD_W-1:0]  product_s;
   logic signed [ACC_W-1:0]   product_ext_s;
   logic signed [DATA_W-1:0]  sat_s;

   iir_sat25 #(.FRAC(FRAC)) u_sat (
      .acc    (acc_r),
      .result (sat_s)
   );

   // Next state, next step, and the selector that goes with them.
   always_comb begin
      state_nx_s = state_r;
      step_nx_s  = step_r;
      case (state_r)
         ST_IDLE: begin
            step_nx_s = 3'd0;
            if (sample_valid) begin
               state_nx_s = ST_MAC;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_MAC: begin
            if (step_r == LAST_STEP) begin
               state_nx_s = ST_OUT;
               step_nx_s  = 3'd0;
            end else begin
               state_nx_s = ST_MAC;
               step_nx_s  = step_r + 3'd1;
            end
         end
         ST_OUT: begin
            state_nx_s = ST_IDLE;
            step_nx_s  = 3'd0;
         end
         default: begin
            state_nx_s = ST_IDLE;
            step_nx_s  = 3'd0;
         end
      endcase
      // Selector and busy are registered alongside the state they describe.
      if (state_nx_s == ST_MAC) begin
         sel_nx_s = step_sel(step_nx_s);
      end else begin
         sel_nx_s = SEL_IDLE;
      end
   end

   // FSM state register with registered selector/busy decode.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         step_r     <= 3'd0;
         selector_r <= SEL_IDLE;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         step_r     <= step_nx_s;
         selector_r <= sel_nx_s;
         busy_r     <= (state_nx_s != ST_IDLE);
      end
   end

   // Operand paired with the coefficient currently selected.
   always_comb begin
      case (step_r)
         3'd0:    operand_s = x0_r;
         3'd1:    operand_s = x1_r;
         3'd2:    operand_s = x2_r;
         3'd3:    operand_s = y1_r;
         3'd4:    operand_s = y2_r;
         default: operand_s = {DATA_W{1'b0}};
      endcase
   end

   // Full-precision product, sign-extended to the accumulator width.
   always_comb begin
      product_s     = PROD_W'(constantes) * PROD_W'(operand_s);
      product_ext_s = {{(ACC_W - PROD_W){product_s[PROD_W-1]}}, product_s};
   end

   // Datapath: sample capture, accumulation, output and delay-line update.
   always_ff @(posedge clk) begin
      if (reset) begin
         x0_r         <= {DATA_W{1'b0}};
         x1_r         <= {DATA_W{1'b0}};
         x2_r         <= {DATA_W{1'b0}};
         y1_r         <= {DATA_W{1'b0}};
         y2_r         <= {DATA_W{1'b0}};
         acc_r        <= {ACC_W{1'b0}};
         sample_out_r <= {DATA_W{1'b0}};
         out_valid_r  <= 1'b0;
         overrun_r    <= 1'b0;
      end else begin
         out_valid_r <= 1'b0;
         // A strobe outside IDLE is dropped; it only raises overrun.
         overrun_r   <= sample_valid && (state_r != ST_IDLE);
         case (state_r)
            ST_IDLE: begin
               if (sample_valid) begin
                  x0_r  <= sample_in;
                  acc_r <= {ACC_W{1'b0}};
               end else begin
                  acc_r <= acc_r;
               end
            end
            ST_MAC: begin
               acc_r <= acc_r + product_ext_s;
            end
            ST_OUT: begin
               sample_out_r <= sat_s;
               out_valid_r  <= 1'b1;
               x2_r         <= x1_r;
               x1_r         <= x0_r;
               y2_r         <= y1_r;
               y1_r         <= sat_s;
            end
            default: begin
               acc_r <= acc_r;
            end
         endcase
      end
   end

   assign selector   = selector_r;
   assign busy       = busy_r;
   assign sample_out = sample_out_r;
   assign out_valid  = out_valid_r;
   assign overrun    = overrun_r;

endmodule

// File: tb/tb_iir_biquad_mac.sv
// Directed bench for iir_biquad_mac with a local coefficient mux model.
module tb_iir_biquad_mac;

   logic               clk = 1'b0;
   logic               reset;
   logic               sample_valid;
   logic signed [24:0] sample_in;
   logic signed [24:0] constantes;
   logic [2:0]         selector;
   logic signed [24:0] sample_out;
   logic               out_valid;
   logic               busy;
   logic               overrun;

   logic signed [24:0] coef [0:7];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign constantes = coef[selector];

   iir_biquad_mac #(.FRAC(14)) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample_in    (sample_in),
      .constantes   (constantes),
      .selector     (selector),
      .sample_out   (sample_out),
      .out_valid    (out_valid),
      .busy         (busy),
      .overrun      (overrun)
   );

   typedef struct {
      logic               do_reset;
      logic signed [24:0] b0, b1, b2, a1, a2;
      logic signed [24:0] x;
      logic signed [24:0] y_exp;
   } vec_t;

   localparam logic [14:0] SEL_SEQ_EXP = 15'b010_011_100_000_001;

   task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_coefs(input logic signed [24:0] b0, b1, b2, a1, a2);
      for (int i = 0; i < 8; i++) coef[i] = 25'sd0;
      coef[2] = b0;
      coef[3] = b1;
      coef[4] = b2;
      coef[0] = a1;
      coef[1] = a2;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Sends one sample and watches 12 cycles; optional extra strobe at cycle strobe_at.
   task automatic run(input logic signed [24:0] x, input int strobe_at,
                      output logic signed [24:0] y, output int lat, output int nvalid,
                      output logic [14:0] sel_seq, output int ovr_at, output int novr);
      y = 25'sd0; lat = 0; nvalid = 0; sel_seq = 15'd0; ovr_at = 0; novr = 0;
      sample_in = x;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         if (c == strobe_at) begin
            sample_valid = 1'b1;
            sample_in = 25'sd5555;
         end
         if (c <= 5) sel_seq = {sel_seq[11:0], selector};
         if (out_valid) begin
            nvalid++;
            if (lat == 0) begin
               lat = c;
               y = sample_out;
            end
         end
         if (overrun) begin
            novr++;
            if (ovr_at == 0) ovr_at = c;
         end
         tick();
         sample_valid = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t               vecs [0:11];
      logic signed [24:0] y;
      int                 lat, nvalid, ovr_at, novr, cnt, found;
      logic [14:0]        sel_seq;

      // Pass-through, recursion, saturation, and a full five-tap case with floor rounding.
      vecs[0]  = '{1'b1, 25'sd16384, 25'sd0,    25'sd0,    25'sd0,     25'sd0,    25'sd1000,     25'sd1000};
      vecs[1]  = '{1'b1, 25'sd16384, 25'sd0,    25'sd0,    25'sd8192,  25'sd0,    25'sd16384,    25'sd16384};
      vecs[2]  = '{1'b0, 25'sd16384, 25'sd0,    25'sd0,    25'sd8192,  25'sd0,    25'sd0,        25'sd8192};
      vecs[3]  = '{1'b0, 25'sd16384, 25'sd0,    25'sd0,    25'sd8192,  25'sd0,    25'sd0,        25'sd4096};
      vecs[4]  = '{1'b0, 25'sd16384, 25'sd0,    25'sd0,    25'sd8192,  25'sd0,    25'sd0,        25'sd2048};
      vecs[5]  = '{1'b1, 25'sd32768, 25'sd0,    25'sd0,    25'sd0,     25'sd0,    25'sd16777215, 25'h0FFFFFF};
      vecs[6]  = '{1'b0, 25'sd32768, 25'sd0,    25'sd0,    25'sd0,     25'sd0,    25'h1000000,   25'h1000000};
      vecs[7]  = '{1'b1, 25'sd16384, 25'sd8192, 25'sd4096, -25'sd4096, 25'sd2048, 25'sd1600,     25'sd1600};
      vecs[8]  = '{1'b0, 25'sd16384, 25'sd8192, 25'sd4096, -25'sd4096, 25'sd2048, 25'sd800,      25'sd1200};
      vecs[9]  = '{1'b0, 25'sd16384, 25'sd8192, 25'sd4096, -25'sd4096, 25'sd2048, -25'sd400,     25'sd300};
      vecs[10] = '{1'b0, 25'sd16384, 25'sd8192, 25'sd4096, -25'sd4096, 25'sd2048, 25'sd0,        25'sd75};
      vecs[11] = '{1'b0, 25'sd16384, 25'sd8192, 25'sd4096, -25'sd4096, 25'sd2048, 25'sd0,        -25'sd82};

      // Reset with a strobe held high: the strobe must not be taken.
      set_coefs(25'sd0, 25'sd0, 25'sd0, 25'sd0, 25'sd0);
      reset = 1'b1;
      sample_valid = 1'b1;
      sample_in = 25'sd123;
      tick();
      tick();
      reset = 1'b0;
      sample_valid = 1'b0;
      check("reset_selector", {29'd0, selector}, 32'sd6);
      check("reset_busy", {31'd0, busy}, 32'sd0);
      check("reset_out_valid", {31'd0, out_valid}, 32'sd0);
      check("reset_sample_out", sample_out, 32'sd0);
      check("reset_overrun", {31'd0, overrun}, 32'sd0);
      tick();
      check("reset_strobe_ignored", {31'd0, busy}, 32'sd0);

      // Table-driven vectors.
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].do_reset) do_reset();
         set_coefs(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].a1, vecs[i].a2);
         run(vecs[i].x, 0, y, lat, nvalid, sel_seq, ovr_at, novr);
         check($sformatf("vec%0d_y", i), y, vecs[i].y_exp);
         check($sformatf("vec%0d_latency", i), lat, 32'sd7);
         check($sformatf("vec%0d_nvalid", i), nvalid, 32'sd1);
         check($sformatf("vec%0d_selseq", i), {17'd0, sel_seq}, {17'd0, SEL_SEQ_EXP});
      end

      // Overrun: extra strobe in k+3 is dropped and flagged in k+4.
      do_reset();
      set_coefs(25'sd16384, 25'sd0, 25'sd0, 25'sd0, 25'sd0);
      run(25'sd1000, 3, y, lat, nvalid, sel_seq, ovr_at, novr);
      check("ovr_pulse_cycle", ovr_at, 32'sd4);
      check("ovr_pulse_count", novr, 32'sd1);
      check("ovr_nvalid", nvalid, 32'sd1);
      check("ovr_y", y, 32'sd1000);
      set_coefs(25'sd0, 25'sd16384, 25'sd0, 25'sd0, 25'sd0);
      run(25'sd0, 0, y, lat, nvalid, sel_seq, ovr_at, novr);
      check("ovr_x1_undisturbed", y, 32'sd1000);

      // Reset mid-MAC during step 2.
      do_reset();
      set_coefs(25'sd16384, 25'sd0, 25'sd0, 25'sd8192, 25'sd0);
      run(25'sd16384, 0, y, lat, nvalid, sel_seq, ovr_at, novr);
      check("rst_mid_pre_y", y, 32'sd16384);
      sample_in = 25'sd0;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      tick();
      tick();
      check("rst_mid_step2_sel", {29'd0, selector}, 32'sd4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_mid_busy", {31'd0, busy}, 32'sd0);
      check("rst_mid_sample_out", sample_out, 32'sd0);
      check("rst_mid_selector", {29'd0, selector}, 32'sd6);
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         if (out_valid) cnt++;
         tick();
      end
      check("rst_mid_no_valid", cnt, 32'sd0);
      run(25'sd16384, 0, y, lat, nvalid, sel_seq, ovr_at, novr);
      check("rst_mid_fresh_y0", y, 32'sd16384);
      run(25'sd0, 0, y, lat, nvalid, sel_seq, ovr_at, novr);
      check("rst_mid_fresh_y1", y, 32'sd8192);

      // Back-to-back: second strobe in the out_valid cycle.
      do_reset();
      set_coefs(25'sd16384, 25'sd0, 25'sd0, 25'sd8192, 25'sd0);
      sample_in = 25'sd16384;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      found = 0;
      novr = 0;
      for (int c = 1; c <= 10; c++) begin
         if (out_valid) begin
            found = c;
            break;
         end
         tick();
      end
      check("b2b_first_latency", found, 32'sd7);
      check("b2b_first_y", sample_out, 32'sd16384);
      sample_in = 25'sd0;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      found = 0;
      for (int c = 1; c <= 10; c++) begin
         if (overrun) novr++;
         if (out_valid) begin
            found = c;
            break;
         end
         tick();
      end
      check("b2b_second_latency", found, 32'sd7);
      check("b2b_second_y", sample_out, 32'sd8192);
      check("b2b_no_overrun", novr, 32'sd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
